// File: rtl/mem_to_reg_mux_if.sv
// Write-back selector bundle: datapath sources and load controls in, selected and registered
// write-back data out. The control/datapath side is the master and the selector is the slave.
interface mem_to_reg_mux_if #(
    parameter int DW = 32
);
    logic [DW-1:0] alu_result;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] pc_plus_8;
    logic [1:0]    mem_to_reg;
    logic [2:0]    ld_type;
    logic          cap_en;
    logic [DW-1:0] wb_data_comb;
    logic [DW-1:0] wb_data;
    logic          sel_err;

    modport master (
        output alu_result, mem_data, pc_plus_8, mem_to_reg, ld_type, cap_en,
        input  wb_data_comb, wb_data, sel_err
    );

    modport slave (
        input  alu_result, mem_data, pc_plus_8, mem_to_reg, ld_type, cap_en,
        output wb_data_comb, wb_data, sel_err
    );
endinterface

// File: rtl/mem_to_reg_mux.sv
// MIPS32 write-back source selector: ALU / PC+8 / size- and sign-adjusted memory data,
// presented combinationally and as a registered copy for the register-file write cycle.
module mem_to_reg_mux #(
    parameter int DW = 32
) (
    input logic              CLK,
    input logic              reset,
    mem_to_reg_mux_if.slave  bus
);
    typedef enum logic [1:0] {
        SEL_ALU  = 2'b00,
        SEL_LINK = 2'b01,
        SEL_MEM  = 2'b10,
        SEL_RSVD = 2'b11
    } sel_e;

    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_H  = 3'd1,
        LD_HU = 3'd2,
        LD_B  = 3'd3,
        LD_BU = 3'd4
    } ld_e;

    logic [DW-1:0] mem_ext;
    logic [DW-1:0] wb_comb;
    logic [DW-1:0] wb_data_d, wb_data_q;
    logic          sel_err_d, sel_err_q;

    // RAM is big-endian: the addressed byte/halfword always sits in the top lanes.
    always_comb begin
        // NOTE: default assigned first so every path drives mem_ext and no latch is inferred.
        mem_ext = bus.mem_data;
        case (ld_e'(bus.ld_type))
            LD_H:    mem_ext = {{(DW-16){bus.mem_data[DW-1]}}, bus.mem_data[DW-1 -: 16]};
            LD_HU:   mem_ext = {{(DW-16){1'b0}},               bus.mem_data[DW-1 -: 16]};
            LD_B:    mem_ext = {{(DW-8){bus.mem_data[DW-1]}},  bus.mem_data[DW-1 -: 8]};
            LD_BU:   mem_ext = {{(DW-8){1'b0}},                bus.mem_data[DW-1 -: 8]};
            default: mem_ext = bus.mem_data;
        endcase
    end

    always_comb begin
        wb_comb = '0;
        case (sel_e'(bus.mem_to_reg))
            SEL_ALU:  wb_comb = bus.alu_result;
            SEL_LINK: wb_comb = bus.pc_plus_8;
            SEL_MEM:  wb_comb = mem_ext;
            default:  wb_comb = '0;
        endcase
    end

    always_comb begin
        wb_data_d = wb_data_q;
        sel_err_d = sel_err_q;
        if (bus.cap_en) begin
            wb_data_d = wb_comb;
            sel_err_d = (sel_e'(bus.mem_to_reg) == SEL_RSVD);
        end
    end

    // Reset is synchronous and overrides a capture on the same edge.
    always_ff @(posedge CLK) begin
        if (reset) begin
            // NOTE: non-blocking assignments for state so all registers update from pre-edge values.
            wb_data_q <= '0;
            sel_err_q <= 1'b0;
        end else begin
            wb_data_q <= wb_data_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign bus.wb_data_comb = wb_comb;
    assign bus.wb_data      = wb_data_q;
    assign bus.sel_err      = sel_err_q;
endmodule

// File: tb/tb_mem_to_reg_mux.sv
// Self-checking bench for mem_to_reg_mux: directed test-plan steps followed by randomized
// steps, all compared against an arithmetic reference model of the write-back rules.
module tb_mem_to_reg_mux;
    logic clk;
    logic reset;
    int   total;
    int   passed;

    logic [31:0] exp_wb;
    logic        exp_err;

    mem_to_reg_mux_if #(.DW(32)) bus ();

    mem_to_reg_mux #(.DW(32)) dut (
        .CLK   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: loads computed as integer division plus two's-complement offset.
    function automatic logic [31:0] model(input logic [1:0] sel, input logic [2:0] ld,
                                          input logic [31:0] alu, input logic [31:0] mem,
                                          input logic [31:0] pc);
        logic [31:0] half, byte_v;
        half   = mem / 32'd65536;
        byte_v = mem / 32'd16777216;
        if (sel == 2'd0) return alu;
        if (sel == 2'd1) return pc;
        if (sel == 2'd3) return 32'd0;
        case (ld)
            3'd1:    return (half >= 32'd32768) ? half + 32'hFFFF_0000 : half;
            3'd2:    return half;
            3'd3:    return (byte_v >= 32'd128) ? byte_v + 32'hFFFF_FF00 : byte_v;
            3'd4:    return byte_v;
            default: return mem;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drive one cycle of inputs after the falling edge, check the combinational value,
    // advance the model across the rising edge, then check the registered outputs.
    task automatic step(input string tag, input logic rst, input logic cap,
                        input logic [1:0] sel, input logic [2:0] ld,
                        input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc);
        logic [31:0] comb_exp;
        reset          = rst;
        bus.cap_en     = cap;
        bus.mem_to_reg = sel;
        bus.ld_type    = ld;
        bus.alu_result = alu;
        bus.mem_data   = mem;
        bus.pc_plus_8  = pc;
        comb_exp       = model(sel, ld, alu, mem, pc);
        #1;
        check({tag, ".comb"}, bus.wb_data_comb, comb_exp);
        @(posedge clk);
        if (rst) begin
            exp_wb  = 32'd0;
            exp_err = 1'b0;
        end else if (cap) begin
            exp_wb  = comb_exp;
            exp_err = (sel == 2'd3);
        end
        @(negedge clk);
        check({tag, ".wb"},  bus.wb_data, exp_wb);
        check({tag, ".err"}, {31'd0, bus.sel_err}, {31'd0, exp_err});
    endtask

    initial begin
        total   = 0;
        passed  = 0;
        exp_wb  = 32'd0;
        exp_err = 1'b0;
        reset   = 1'b1;
        bus.cap_en = 1'b0; bus.mem_to_reg = 2'd0; bus.ld_type = 3'd0;
        bus.alu_result = 32'd0; bus.mem_data = 32'd0; bus.pc_plus_8 = 32'd0;
        @(negedge clk);

        step("reset", 1'b1, 1'b1, 2'd2, 3'd0, 32'h1234_5678, 32'hFFFF_FFFF, 32'h4);
        check("reset_wb", bus.wb_data, 32'h0);
        step("alu", 1'b0, 1'b1, 2'd0, 3'd0, 32'h0000_002C, 32'h0, 32'h0);
        check("alu_wb", bus.wb_data, 32'h2C);

        step("lw",  1'b0, 1'b1, 2'd2, 3'd0, 32'h0, 32'h8A7F_1234, 32'h0);
        check("lw_k",  bus.wb_data, 32'h8A7F_1234);
        step("lh",  1'b0, 1'b1, 2'd2, 3'd1, 32'h0, 32'h8A7F_1234, 32'h0);
        check("lh_k",  bus.wb_data, 32'hFFFF_8A7F);
        step("lhu", 1'b0, 1'b1, 2'd2, 3'd2, 32'h0, 32'h8A7F_1234, 32'h0);
        check("lhu_k", bus.wb_data, 32'h0000_8A7F);
        step("lb",  1'b0, 1'b1, 2'd2, 3'd3, 32'h0, 32'h8A7F_1234, 32'h0);
        check("lb_k",  bus.wb_data, 32'hFFFF_FF8A);
        step("lbu", 1'b0, 1'b1, 2'd2, 3'd4, 32'h0, 32'h8A7F_1234, 32'h0);
        check("lbu_k", bus.wb_data, 32'h0000_008A);
        step("ld7", 1'b0, 1'b1, 2'd2, 3'd7, 32'h0, 32'h8A7F_1234, 32'h0);
        check("ld7_k", bus.wb_data, 32'h8A7F_1234);

        step("lb_pos", 1'b0, 1'b1, 2'd2, 3'd3, 32'h0, 32'h7F80_0000, 32'h0);
        check("lb_pos_k", bus.wb_data, 32'h0000_007F);
        step("lh_pos", 1'b0, 1'b1, 2'd2, 3'd1, 32'h0, 32'h7F80_0000, 32'h0);
        check("lh_pos_k", bus.wb_data, 32'h0000_7F80);

        step("link", 1'b0, 1'b1, 2'd1, 3'd3, 32'hAAAA_AAAA, 32'h8000_0000, 32'h0000_0010);
        check("link_k", bus.wb_data, 32'h10);

        step("rsvd", 1'b0, 1'b1, 2'd3, 3'd0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
        check("rsvd_err", {31'd0, bus.sel_err}, 32'd1);
        check("rsvd_wb", bus.wb_data, 32'h0);
        step("clr_err", 1'b0, 1'b1, 2'd0, 3'd0, 32'd5, 32'h0, 32'h0);
        check("clr_err_k", {31'd0, bus.sel_err}, 32'd0);

        step("beef", 1'b0, 1'b1, 2'd0, 3'd0, 32'hDEAD_BEEF, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++)
            step("hold", 1'b0, 1'b0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                 $urandom, $urandom, $urandom);
        check("hold_k", bus.wb_data, 32'hDEAD_BEEF);
        step("rst_pri", 1'b1, 1'b1, 2'd0, 3'd0, 32'h5555_5555, 32'h0, 32'h0);
        check("rst_pri_k", bus.wb_data, 32'h0);
        step("post_rst", 1'b0, 1'b1, 2'd2, 3'd4, 32'h0, 32'hC300_0000, 32'h0);
        check("post_rst_k", bus.wb_data, 32'h0000_00C3);

        for (int i = 0; i < 200; i++)
            step("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                 $urandom, $urandom, $urandom);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_to_reg_mux.md
# mem_to_reg_mux

Write-back source selector for the multi-cycle MIPS32 datapath. It picks the register-file write data from one of three sources: ALU result, PC+8 (link), or memory read data. Memory data is size- and sign-adjusted for LW/LH/LHU/LB/LBU. It presents the result combinationally and also as a registered copy held for the register-file write cycle.

## Interface
Parameters:
- `DW`, 32: data width; only 32 is supported.

Ports:
- `CLK`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high; clears all registered outputs.
- `alu_result`  in  32: ALU output (`AluOut`).
- `mem_data`  in  32: RAM word. The byte at the load address is in [31:24], then address+1 in [23:16], and so on (big-endian).
- `pc_plus_8`  in  32: link value for JAL/JALR.
- `mem_to_reg`  in  2: source select.
  - 00: ALU.
  - 01: PC+8.
  - 10: memory.
  - 11: reserved.
- `ld_type`  in  3: load format, used only when `mem_to_reg`=10.
  - 000: LW.
  - 001: LH.
  - 010: LHU.
  - 011: LB.
  - 100: LBU.
  - 101–111: treated as LW.
- `cap_en`  in  1: capture the combinational result into `wb_data` on this edge.
- `wb_data_comb`  out  32: combinational selected/extended value.
- `wb_data`  out  32: registered write-back value.
- `sel_err`  out  1: registered. Set when a capture occurred with `mem_to_reg`=11.

## Operation
- `wb_data_comb` by select:
  - 00 → `alu_result`.
  - 01 → `pc_plus_8`.
  - 10 → extended memory value per `ld_type`.
  - 11 → 32'h0000_0000.
- Memory extraction always uses the most-significant lanes of `mem_data`, because RAM returns the addressed byte first:
  - LW: `mem_data` unchanged.
  - LH: {16 copies of `mem_data`[31], `mem_data`[31:16]}.
  - LHU: {16'h0, `mem_data`[31:16]}.
  - LB: {24 copies of `mem_data`[31], `mem_data`[31:24]}.
  - LBU: {24'h0, `mem_data`[31:24]}.
- `ld_type` is ignored for selects 00, 01 and 11.
- Registered path:
  - `cap_en`=1: `wb_data` ← `wb_data_comb`, and `sel_err` ← (`mem_to_reg`==11).
  - `cap_en`=0: both hold their values.
- No arithmetic other than replication for extension; there is no overflow or carry.
- Every combinational output is defined for every input value; no latches are inferred.

## Timing
- `wb_data_comb`: zero latency; follows inputs within the same cycle.
- `wb_data`/`sel_err`: one-cycle latency. The value captured at edge N is visible after edge N and stable until the next capturing edge.
- Reset:
  - On any edge with `reset`=1: `wb_data`=0 and `sel_err`=0.
  - Reset has priority over `cap_en`.
  - Reset does not affect `wb_data_comb`.
- Reset during a load (mid-operation): the registered value is discarded. The next capture after reset deasserts behaves normally.
- Simultaneous select and input change on the capture edge: the sampled value is the one present at the edge (setup satisfied by the control FSM).
- Back-to-back `cap_en` on consecutive cycles: each cycle's value is captured independently, with no bubble.

## Test plan
- Reset, then ALU select:
  - Assert `reset` for one edge with `cap_en`=1 → `wb_data`=0, `sel_err`=0.
  - Then `mem_to_reg`=00, `alu_result`=32'h0000_002C, `cap_en`=1 → `wb_data_comb`=32'h2C immediately, `wb_data`=32'h2C after the edge.
- Memory loads with `mem_to_reg`=10 and `mem_data`=32'h8A7F_1234:
  - LW → 32'h8A7F1234.
  - LH → 32'hFFFF8A7F.
  - LHU → 32'h00008A7F.
  - LB → 32'hFFFFFF8A.
  - LBU → 32'h0000008A.
- Positive sign cases with `mem_data`=32'h7F80_0000:
  - LB → 32'h0000007F.
  - LH → 32'h00007F80.
- Link select: `mem_to_reg`=01, `pc_plus_8`=32'h0000_0010 → 32'h10; `ld_type`=011 has no effect.
- Reserved select and error flag:
  - `mem_to_reg`=11 with `cap_en`=1 → `wb_data`=0, `sel_err`=1.
  - Next capture with select 00 and `alu_result`=5 → `wb_data`=5, `sel_err`=0.
- Hold and priority:
  - Capture 32'hDEAD_BEEF, then drop `cap_en` and change all inputs for 3 cycles → `wb_data` stays 32'hDEADBEEF.
  - `reset`=1 with `cap_en`=1 on the same edge → `wb_data`=0.
